// File: rtl/fifo_read_pointer.sv
// fifo_read_pointer: read-side controller of the single-clock FIFO with a
// first-word-fall-through output stage and valid/ready handshake.
module fifo_read_pointer #(
    parameter int PTR_LENGTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [PTR_LENGTH-1:0] wptr,
    input  logic                  flush,
    input  logic                  dout_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [PTR_LENGTH-1:0] rptr,
    output logic                  mem_rd_en,
    output logic [PTR_LENGTH-2:0] mem_raddr,
    output logic                  fifo_empty,
    output logic                  almost_empty,
    output logic [PTR_LENGTH-1:0] level,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  err_underflow
);
    typedef enum logic {EMPTY = 1'b0, VALID = 1'b1} state_t;

    localparam logic [PTR_LENGTH-1:0] AE_LVL = PTR_LENGTH'(AE_THRESH);
    localparam logic [PTR_LENGTH-1:0] ONE    = PTR_LENGTH'(1);

    state_t                  state_q, state_d;
    logic [PTR_LENGTH-1:0]   rptr_q, rptr_d;
    logic                    err_q, err_d;
    logic                    pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            rptr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rptr_q  <= rptr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        dout_valid = (state_q == VALID);
        fifo_empty = (wptr == rptr_q);
        pop        = dout_valid & dout_ready;
        // the read doubles as prefetch when idle and as refill alongside a pop
        mem_rd_en  = ~flush & ~fifo_empty & (~dout_valid | dout_ready);
        rptr_d     = flush ? wptr : mem_rd_en ? rptr_q + ONE : rptr_q;
        state_d    = flush ? EMPTY : mem_rd_en ? VALID : pop ? EMPTY : state_q;
        err_d      = flush ? 1'b0 : (dout_ready & ~dout_valid) ? 1'b1 : err_q;
    end

    assign rptr          = rptr_q;
    assign mem_raddr     = rptr_q[PTR_LENGTH-2:0];
    assign level         = (wptr - rptr_q) + {{(PTR_LENGTH-1){1'b0}}, dout_valid};
    assign almost_empty  = (level <= AE_LVL);
    assign dout          = mem_rdata;
    assign err_underflow = err_q;
endmodule

// File: doc/fifo_read_pointer.md
Name: fifo_read_pointer

Overview:
- Read-side controller for the synchronous single-clock FIFO. It is the counterpart of the write-pointer block.
- Owns the read pointer and derives the empty, level and almost-empty status from the write pointer.
- Drives the read port of the synchronous-read FIFO RAM.
- Presents a first-word-fall-through output with a valid/ready handshake, sustaining one word per cycle.

Parameters:
- PTR_LENGTH, 5: pointer width. MSB is the wrap bit; the lower PTR_LENGTH-1 bits are the RAM address. FIFO depth = 2^(PTR_LENGTH-1) = 16. Minimum value 2.
- DATA_WIDTH, 8: word width.
- AE_THRESH, 2: almost_empty asserts when level <= AE_THRESH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- wptr  in  PTR_LENGTH  write pointer, registered, from the write side (same encoding as rptr).
- flush  in  1  synchronous discard of all unread data.
- dout_ready  in  1  consumer accepts dout this cycle.
- mem_rdata  in  DATA_WIDTH  RAM read data. Valid the cycle after mem_rd_en and held until the next mem_rd_en.
- rptr  out  PTR_LENGTH  read pointer.
- mem_rd_en  out  1  RAM read strobe (combinational).
- mem_raddr  out  PTR_LENGTH-1  equals rptr[PTR_LENGTH-2:0].
- fifo_empty  out  1  RAM holds no unfetched words; fed back to the write side.
- almost_empty  out  1  level <= AE_THRESH.
- level  out  PTR_LENGTH  total words held, including the one on dout.
- dout  out  DATA_WIDTH  output word; equals mem_rdata.
- dout_valid  out  1  dout holds a valid word.
- err_underflow  out  1  sticky error flag.

Behaviour:
- Reset: when reset_n=0, all registers clear immediately, independent of clk: rptr=0, dout_valid=0, err_underflow=0. Consequently fifo_empty=1 (given wptr=0), level=0 and almost_empty=1.
- fifo_empty = (wptr == rptr), combinational.
- pop = dout_valid & dout_ready.
- mem_rd_en = ~flush & ~fifo_empty & (~dout_valid | dout_ready).
  - Covers both prefetch into an empty output stage and the refill issued in the same cycle as a pop.
- rptr: on each clk edge with mem_rd_en=1, rptr <= rptr + 1, modulo 2^PTR_LENGTH. The address wraps 15 -> 0 and the wrap bit toggles. Otherwise rptr holds.
- dout_valid next-state, in priority order:
  1. flush -> 0
  2. mem_rd_en -> 1
  3. pop -> 0
  4. otherwise hold
- Output state machine:
  - EMPTY (dout_valid=0):
    - RAM not empty: issue read, go to VALID next cycle.
    - RAM empty: stay.
  - VALID:
    - pop with RAM non-empty: refill in the same cycle, stay VALID; back-to-back, no bubble.
    - pop with RAM empty: go to EMPTY.
    - no pop: hold; dout stays stable.
- Latency: a write to an empty FIFO updates wptr at edge N. Then mem_rd_en=1 in cycle N, and dout_valid=1 with the word from edge N+1.
- Flush:
  - rptr <= wptr, dout_valid <= 0, err_underflow <= 0.
  - mem_rd_en is forced to 0 in the flush cycle.
  - Words written in the flush cycle land after the flush point and are retained.
- level = (wptr - rptr) mod 2^PTR_LENGTH + dout_valid. Maximum value is depth + 1 = 17.
- err_underflow: set on a clk edge where dout_ready=1 and dout_valid=0. Sticky until flush or reset.
- Simultaneous write and pop on a one-word FIFO: the refill read is based on the current wptr. The newly written word becomes visible the next cycle and triggers a prefetch from EMPTY. This produces one bubble, which is accepted behaviour.
- Reset asserted mid-stream: all outputs return to their reset values immediately. In-flight data is discarded; the write side is reset together with this block.

Test Plan:
- Reset, then write 0xA5 (wptr 0->1) -> next cycle mem_rd_en=1, mem_raddr=0; following cycle dout_valid=1, dout=0xA5, rptr=1, level=1, fifo_empty=1.
- Write 16 words 0x00..0x0F with dout_ready=0 -> after prefetch, level=16, dout=0x00, rptr=1. Then hold dout_ready=1 -> dout shows 0x01..0x0F on consecutive cycles with no bubbles, then dout_valid=0 and level=0.
- Stream 40 words through with writes and reads interleaved -> mem_raddr wraps 15->0 twice, rptr bit4 toggles, data order is preserved, and level never exceeds 17.
- dout_ready=1 with the FIFO empty -> err_underflow=1 stays set through later traffic; flush clears it.
- Load 5 words, pop 1, assert flush for one cycle -> rptr=wptr, dout_valid=0, level=0. A subsequent write of 0x3C appears on dout two cycles later.
- Assert reset_n=0 mid-stream, between clock edges -> rptr=0 and dout_valid=0 immediately, without waiting for an edge.
